// File: rtl/game_master_fsm_multi_target.sv
// game_master_fsm_multi_target
// Round sequencer for the shooting game: N_TARGETS target sprites, one bullet
// and one torpedo. It keeps a saturating score and a life counter, decides
// win or loss, and holds a game-over state until the player presses the key
// again. Every output is registered and shows the state of the previous cycle.
//
// Optional feature: define GAME_MASTER_TIMER_EN to end the game when the
// end-of-game timer stops running. Once armed, a stopped timer ends the game
// as a loss.
module game_master_fsm_multi_target #(
  parameter int N_TARGETS   = 3,
  parameter int WIN_SCORE   = 3,
  parameter int START_LIVES = 3,
  parameter int SCORE_W     = $clog2(WIN_SCORE + 1),
  parameter int LIVES_W     = $clog2(START_LIVES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 launch_key,
  input  logic [N_TARGETS-1:0] target_within_screen,
  input  logic                 bullet_within_screen,
  input  logic                 torpedo_within_screen,
  input  logic                 collision,
  input  logic                 collision_bullet,
  input  logic                 end_of_game_timer_running,
  output logic [N_TARGETS-1:0] target_write_xy,
  output logic [N_TARGETS-1:0] target_write_dxy,
  output logic [N_TARGETS-1:0] target_enable_update,
  output logic                 bullet_write_xy,
  output logic                 bullet_write_dxy,
  output logic                 bullet_enable_update,
  output logic                 torpedo_write_xy,
  output logic                 torpedo_write_dxy,
  output logic                 torpedo_enable_update,
  output logic                 end_of_game_timer_start,
  output logic                 game_over,
  output logic                 game_won,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   n_lifes
);

  typedef enum logic [2:0] {
    START_GAME,
    START_ROUND,
    AIM,
    SHOOT,
    END_ROUND,
    END_GAME
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  state_t state;
  logic   launch_q;     // previous launch_key level, for edge detection
  logic   shoot_first;  // high during the first cycle spent in SHOOT
  logic   launch_rise;
  logic   targets_off;
  logic   sprites_off;
  logic   timer_expired;

  assign launch_rise = launch_key & ~launch_q;
  assign targets_off = ~&target_within_screen;
  assign sprites_off = targets_off | ~bullet_within_screen | ~torpedo_within_screen;

`ifdef GAME_MASTER_TIMER_EN
  logic armed;  // set once the timer has been seen running in this game
  assign timer_expired = armed & ~end_of_game_timer_running;
`else
  logic unused_timer_running;
  assign unused_timer_running = end_of_game_timer_running;
  assign timer_expired        = 1'b0;
`endif

  // State sequencing, score/life accounting and registered sprite strobes.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of state and counters; mixing in = would make outputs depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= START_GAME;
      launch_q                <= 1'b0;
      shoot_first             <= 1'b0;
      score                   <= '0;
      n_lifes                 <= LIVES_INIT;
      game_won                <= 1'b0;
      game_over               <= 1'b0;
      end_of_game_timer_start <= 1'b0;
      target_write_xy         <= '0;
      target_write_dxy        <= '0;
      target_enable_update    <= '0;
      bullet_write_xy         <= 1'b0;
      bullet_write_dxy        <= 1'b0;
      bullet_enable_update    <= 1'b0;
      torpedo_write_xy        <= 1'b0;
      torpedo_write_dxy       <= 1'b0;
      torpedo_enable_update   <= 1'b0;
`ifdef GAME_MASTER_TIMER_EN
      armed                   <= 1'b0;
`endif
    end else begin
      launch_q    <= launch_key;
      shoot_first <= (state == AIM);

      // Outputs decoded from the state occupied this cycle, visible next cycle.
      end_of_game_timer_start <= (state == START_GAME);
      target_write_xy         <= {N_TARGETS{state == START_ROUND}};
      target_write_dxy        <= {N_TARGETS{state == START_ROUND}};
      target_enable_update    <= {N_TARGETS{(state == AIM) || (state == SHOOT)}};
      bullet_write_xy         <= (state == START_ROUND);
      torpedo_write_xy        <= (state == START_ROUND);
      bullet_write_dxy        <= (state == SHOOT) && shoot_first;
      torpedo_write_dxy       <= (state == SHOOT) && shoot_first;
      bullet_enable_update    <= (state == SHOOT);
      torpedo_enable_update   <= (state == SHOOT);
      game_over               <= (state == END_GAME);

`ifdef GAME_MASTER_TIMER_EN
      armed <= (state == START_GAME) ? 1'b0 : (armed | end_of_game_timer_running);
`endif

      case (state)
        START_GAME: begin
          score    <= '0;
          n_lifes  <= LIVES_INIT;
          game_won <= 1'b0;
          state    <= START_ROUND;
        end
        START_ROUND: begin
          if (timer_expired) begin
            game_won <= 1'b0;
            state    <= END_GAME;
          end else begin
            state <= AIM;
          end
        end
        AIM, SHOOT: begin
          // A simultaneous torpedo hit wins over a bullet hit.
          if (collision) begin
            if (n_lifes != '0) n_lifes <= n_lifes - 1'b1;
            state <= END_ROUND;
          end else if (collision_bullet) begin
            if (score != SCORE_MAX) score <= score + 1'b1;
            state <= END_ROUND;
          end else if (timer_expired) begin
            game_won <= 1'b0;
            state    <= END_GAME;
          end else if ((state == AIM) ? targets_off : sprites_off) begin
            state <= END_ROUND;
          end else if ((state == AIM) && launch_rise) begin
            state <= SHOOT;
          end
        end
        END_ROUND: begin
          if (score == SCORE_MAX) begin
            game_won <= 1'b1;
            state    <= END_GAME;
          end else if (n_lifes == '0) begin
            game_won <= 1'b0;
            state    <= END_GAME;
          end else begin
            state <= START_ROUND;
          end
        end
        END_GAME: begin
          if (launch_rise) state <= START_GAME;
        end
        default: state <= START_GAME;
      endcase
    end
  end

endmodule

// File: tb/tb_game_master_fsm_multi_target.sv
// Self-checking bench for game_master_fsm_multi_target: directed scenarios
// with literal expectations, then randomized play compared every cycle
// against a behavioural model of the game rules.
module tb_game_master_fsm_multi_target;

  localparam int N_TARGETS   = 3;
  localparam int WIN_SCORE   = 3;
  localparam int START_LIVES = 3;
  localparam int SCORE_W     = $clog2(WIN_SCORE + 1);
  localparam int LIVES_W     = $clog2(START_LIVES + 1);
  localparam logic [N_TARGETS-1:0] ALL_T = {N_TARGETS{1'b1}};
`ifdef GAME_MASTER_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 launch_key;
  logic [N_TARGETS-1:0] target_within_screen;
  logic                 bullet_within_screen;
  logic                 torpedo_within_screen;
  logic                 collision;
  logic                 collision_bullet;
  logic                 end_of_game_timer_running;
  logic [N_TARGETS-1:0] target_write_xy;
  logic [N_TARGETS-1:0] target_write_dxy;
  logic [N_TARGETS-1:0] target_enable_update;
  logic                 bullet_write_xy;
  logic                 bullet_write_dxy;
  logic                 bullet_enable_update;
  logic                 torpedo_write_xy;
  logic                 torpedo_write_dxy;
  logic                 torpedo_enable_update;
  logic                 end_of_game_timer_start;
  logic                 game_over;
  logic                 game_won;
  logic [SCORE_W-1:0]   score;
  logic [LIVES_W-1:0]   n_lifes;

  int total = 0;
  int bad   = 0;

  game_master_fsm_multi_target #(
    .N_TARGETS  (N_TARGETS),
    .WIN_SCORE  (WIN_SCORE),
    .START_LIVES(START_LIVES)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .launch_key               (launch_key),
    .target_within_screen     (target_within_screen),
    .bullet_within_screen     (bullet_within_screen),
    .torpedo_within_screen    (torpedo_within_screen),
    .collision                (collision),
    .collision_bullet         (collision_bullet),
    .end_of_game_timer_running(end_of_game_timer_running),
    .target_write_xy          (target_write_xy),
    .target_write_dxy         (target_write_dxy),
    .target_enable_update     (target_enable_update),
    .bullet_write_xy          (bullet_write_xy),
    .bullet_write_dxy         (bullet_write_dxy),
    .bullet_enable_update     (bullet_enable_update),
    .torpedo_write_xy         (torpedo_write_xy),
    .torpedo_write_dxy        (torpedo_write_dxy),
    .torpedo_enable_update    (torpedo_enable_update),
    .end_of_game_timer_start  (end_of_game_timer_start),
    .game_over                (game_over),
    .game_won                 (game_won),
    .score                    (score),
    .n_lifes                  (n_lifes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the game rules ----------------
  typedef enum {M_NEW, M_DEAL, M_WAIT, M_FIRE, M_TALLY, M_OVER} mphase_t;
  mphase_t ph, ph_old;
  bit prev_key, fire_first, armed, m_won, m_rise, m_expire, m_off;
  int m_score, m_lives;
  // expected registered outputs
  bit x_start, x_deal, x_aim, x_fire, x_fire1, x_over;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_NEW; prev_key = 0; fire_first = 0; armed = 0;
      m_score = 0; m_lives = START_LIVES; m_won = 0;
      x_start = 0; x_deal = 0; x_aim = 0; x_fire = 0; x_fire1 = 0; x_over = 0;
    end else begin
      m_rise   = launch_key && !prev_key;
      m_expire = TIMER_EN && armed && !end_of_game_timer_running;
      x_start  = (ph == M_NEW);
      x_deal   = (ph == M_DEAL);
      x_aim    = (ph == M_WAIT) || (ph == M_FIRE);
      x_fire   = (ph == M_FIRE);
      x_fire1  = (ph == M_FIRE) && fire_first;
      x_over   = (ph == M_OVER);
      fire_first = (ph == M_WAIT);
      ph_old = ph;
      case (ph)
        M_NEW: begin m_score = 0; m_lives = START_LIVES; m_won = 0; ph = M_DEAL; end
        M_DEAL: if (m_expire) begin ph = M_OVER; m_won = 0; end else ph = M_WAIT;
        M_WAIT, M_FIRE: begin
          m_off = (target_within_screen != ALL_T);
          if (ph == M_FIRE) m_off = m_off || !bullet_within_screen || !torpedo_within_screen;
          if (collision) begin
            if (m_lives > 0) m_lives--;
            ph = M_TALLY;
          end else if (collision_bullet) begin
            if (m_score < WIN_SCORE) m_score++;
            ph = M_TALLY;
          end else if (m_expire) begin
            ph = M_OVER; m_won = 0;
          end else if (m_off) begin
            ph = M_TALLY;
          end else if (ph == M_WAIT && m_rise) begin
            ph = M_FIRE;
          end
        end
        M_TALLY: begin
          if (m_score == WIN_SCORE) begin ph = M_OVER; m_won = 1; end
          else if (m_lives == 0) begin ph = M_OVER; m_won = 0; end
          else ph = M_DEAL;
        end
        M_OVER: if (m_rise) ph = M_NEW;
        default: ph = M_NEW;
      endcase
      armed = (ph_old == M_NEW) ? 1'b0 : (armed || end_of_game_timer_running);
      prev_key = launch_key;
    end
  end

  // Compare every DUT output against the model each cycle, mid-period.
  always @(negedge clk) begin
    check("m_start",      32'(end_of_game_timer_start), 32'(x_start));
    check("m_t_xy",       32'(target_write_xy),         x_deal ? 32'(ALL_T) : 32'd0);
    check("m_t_dxy",      32'(target_write_dxy),        x_deal ? 32'(ALL_T) : 32'd0);
    check("m_t_en",       32'(target_enable_update),    x_aim  ? 32'(ALL_T) : 32'd0);
    check("m_b_xy",       32'(bullet_write_xy),         32'(x_deal));
    check("m_p_xy",       32'(torpedo_write_xy),        32'(x_deal));
    check("m_b_dxy",      32'(bullet_write_dxy),        32'(x_fire1));
    check("m_p_dxy",      32'(torpedo_write_dxy),       32'(x_fire1));
    check("m_b_en",       32'(bullet_enable_update),    32'(x_fire));
    check("m_p_en",       32'(torpedo_enable_update),   32'(x_fire));
    check("m_game_over",  32'(game_over),               32'(x_over));
    check("m_game_won",   32'(game_won),                32'(m_won));
    check("m_score",      32'(score),                   32'(m_score));
    check("m_lives",      32'(n_lifes),                 32'(m_lives));
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the round-start strobe shows; the FSM is then in AIM.
  task automatic wait_for_write(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (target_write_xy == ALL_T) seen = 1;
    end
    check("wait_round_start", 32'(seen), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    launch_key = 1'b0;
    target_within_screen = ALL_T;
    bullet_within_screen = 1'b1;
    torpedo_within_screen = 1'b1;
    collision = 1'b0;
    collision_bullet = 1'b0;
    end_of_game_timer_running = 1'b0;
    #12;
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(n_lifes), 32'd3);
    check("rst_over",  32'(game_over), 32'd0);
    check("rst_start", 32'(end_of_game_timer_start), 32'd0);
    #10 rst_n = 1'b1;

    // Power-up sequence with idle inputs.
    tick();
    check("c1_start", 32'(end_of_game_timer_start), 32'd1);
    check("c1_t_xy",  32'(target_write_xy), 32'd0);
    tick();
    check("c2_start", 32'(end_of_game_timer_start), 32'd0);
    check("c2_t_xy",  32'(target_write_xy), 32'b111);
    check("c2_b_xy",  32'(bullet_write_xy), 32'd1);
    tick();
    check("c3_t_en",  32'(target_enable_update), 32'b111);
    check("c3_t_xy",  32'(target_write_xy), 32'd0);
    check("c3_score", 32'(score), 32'd0);
    check("c3_lives", 32'(n_lifes), 32'd3);

    // Fire: single dxy pulse, enables held, then a target leaves the screen.
    launch_key = 1'b1;
    tick();
    tick();
    check("shoot_b_dxy1", 32'(bullet_write_dxy), 32'd1);
    check("shoot_p_dxy1", 32'(torpedo_write_dxy), 32'd1);
    check("shoot_b_en1",  32'(bullet_enable_update), 32'd1);
    tick();
    check("shoot_b_dxy2", 32'(bullet_write_dxy), 32'd0);
    check("shoot_p_en2",  32'(torpedo_enable_update), 32'd1);
    target_within_screen = 3'b101;
    tick();
    target_within_screen = ALL_T;
    launch_key = 1'b0;
    tick();
    check("eround_b_en", 32'(bullet_enable_update), 32'd0);
    tick();
    check("reround_t_xy",  32'(target_write_xy), 32'b111);
    check("reround_score", 32'(score), 32'd0);
    check("reround_lives", 32'(n_lifes), 32'd3);

    // Three scoring rounds win the game; further hits do not count.
    for (int i = 0; i < 3; i++) begin
      collision_bullet = 1'b1;
      tick();
      collision_bullet = 1'b0;
      check("win_score", 32'(score), 32'(i + 1));
      if (i < 2) wait_for_write(8);
    end
    tick();
    check("win_won", 32'(game_won), 32'd1);
    tick();
    check("win_over", 32'(game_over), 32'd1);
    collision_bullet = 1'b1;
    tick();
    collision_bullet = 1'b0;
    tick();
    check("win_score_sat", 32'(score), 32'd3);
    check("win_over_held", 32'(game_over), 32'd1);

    // Restart with the key held: no SHOOT until release and re-press.
    launch_key = 1'b1;
    tick();
    tick();
    check("restart_start", 32'(end_of_game_timer_start), 32'd1);
    check("restart_won",   32'(game_won), 32'd0);
    check("restart_score", 32'(score), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_no_shoot", 32'(bullet_enable_update), 32'd0);
    end
    launch_key = 1'b0;
    tick();
    launch_key = 1'b1;
    tick();
    tick();
    check("repress_b_dxy", 32'(bullet_write_dxy), 32'd1);

    // Asynchronous reset in SHOOT drops every strobe at once.
    #2 rst_n = 1'b0;
    #1;
    check("arst_t_en", 32'(target_enable_update), 32'd0);
    check("arst_b_en", 32'(bullet_enable_update), 32'd0);
    check("arst_p_en", 32'(torpedo_enable_update), 32'd0);
    check("arst_b_dxy", 32'(bullet_write_dxy), 32'd0);
    launch_key = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous torpedo and bullet hits: only lives are lost.
    wait_for_write(8);
    for (int i = 0; i < 3; i++) begin
      collision = 1'b1;
      collision_bullet = 1'b1;
      tick();
      collision = 1'b0;
      collision_bullet = 1'b0;
      check("lose_lives", 32'(n_lifes), 32'(2 - i));
      check("lose_score", 32'(score), 32'd0);
      if (i < 2) wait_for_write(8);
    end
    tick();
    tick();
    check("lose_over", 32'(game_over), 32'd1);
    check("lose_won",  32'(game_won), 32'd0);
    launch_key = 1'b1;
    tick();
    tick();
    check("lose_restart_lives", 32'(n_lifes), 32'd3);
    launch_key = 1'b0;

    // Timer runs then stops during AIM.
    wait_for_write(8);
    end_of_game_timer_running = 1'b1;
    tick();
    tick();
    end_of_game_timer_running = 1'b0;
    tick();
    tick();
    tick();
    check("timer_over",  32'(game_over), 32'(TIMER_EN));
    check("timer_won",   32'(game_won), 32'd0);
    check("timer_t_en",  32'(target_enable_update), TIMER_EN ? 32'd0 : 32'b111);

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      collision        = ($urandom_range(0, 19) == 0);
      collision_bullet = ($urandom_range(0, 14) == 0);
      for (int t = 0; t < N_TARGETS; t++)
        target_within_screen[t] = ($urandom_range(0, 29) != 0);
      bullet_within_screen  = ($urandom_range(0, 9) != 0);
      torpedo_within_screen = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) launch_key = ~launch_key;
      end_of_game_timer_running = ($urandom_range(0, 39) != 0);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
